// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared types and constants for the junction light sequencer:
//                phase state encoding, lamp patterns and default phase
//                durations (in timebase ticks).
//  Revision    : 1.0  initial release
// ============================================================================
package traffic_pkg;

  // Phase state encoding; codes 6 and 7 are unused and recover to ALL_RED_B.
  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5
  } state_e;

  // Lamp patterns, ordered {red, yellow, green}.
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // Default phase durations in ticks and the counter width that holds them.
  localparam int DEF_GREEN_TICKS  = 10;
  localparam int DEF_YELLOW_TICKS = 3;
  localparam int DEF_ALLRED_TICKS = 2;
  localparam int DEF_CNT_W        = 5;

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/traffic_phase_sequencer_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_timer
//  Description : Down-counter timing one light phase. Loads duration-1 on
//                phase entry, decrements once per timebase tick and flags
//                expiry on the tick where the count is already zero. The
//                count saturates at zero so a phase can be held open.
//  Revision    : 1.0  initial release
// ============================================================================
module phase_timer #(
  parameter int               CNT_W       = 5,
  parameter logic [CNT_W-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             tick,
  output logic             expired,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: a load wins over a tick; otherwise count down to zero and stop.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Counter register; reset value matches the duration of the reset phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RESET_VALUE;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = tick && (count_q == '0);
  assign count   = count_q;

endmodule : phase_timer
`default_nettype wire

// File: rtl/traffic_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_phase_sequencer
//  Description : Two-road junction light sequencer with pedestrian walk lamp.
//                Main road rests on green and yields to a side-road car or a
//                latched pedestrian request once its minimum green has run.
//                All phase durations are counted in timebase ticks.
//  Revision    : 1.0  initial release
// ============================================================================
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
  parameter int YELLOW_TICKS = DEF_YELLOW_TICKS,
  parameter int ALLRED_TICKS = DEF_ALLRED_TICKS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       controller_reset,
  input  logic       tick_enable,
  input  logic       side_sensor,
  input  logic       ped_request,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       ped_ack
);

  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TICKS - 1);

  // Timer reload value for the phase being entered.
  function automatic logic [CNT_W-1:0] phase_load(input state_e s);
    case (s)
      MAIN_GREEN, SIDE_GREEN:   return GREEN_LOAD;
      MAIN_YELLOW, SIDE_YELLOW: return YELLOW_LOAD;
      default:                  return ALLRED_LOAD;
    endcase
  endfunction

  state_e           state_q;
  state_e           state_d;

  logic             ped_pending_q;
  logic             ped_pending_d;
  logic             walk_latched_q;
  logic             walk_latched_d;

  logic [2:0]       main_light_q;
  logic [2:0]       main_light_d;
  logic [2:0]       side_light_q;
  logic [2:0]       side_light_d;
  logic             walk_q;
  logic             walk_d;
  logic             ped_ack_q;
  logic             ped_ack_d;

  logic             timer_load;
  logic [CNT_W-1:0] timer_load_value;
  logic             timer_expired;
  logic [CNT_W-1:0] timer_count;

  logic             demand;
  logic             green_rest_done;
  logic             side_green_entry;

  // A waiting side car or a latched pedestrian asks main green to yield.
  assign demand          = side_sensor | ped_pending_q;
  // Minimum main green has elapsed once the saturating count sits at zero.
  assign green_rest_done = (timer_count == '0);

  phase_timer #(
    .CNT_W       (CNT_W),
    .RESET_VALUE (ALLRED_LOAD)
  ) u_phase_timer (
    .clk        (clk),
    .rst_n      (controller_reset),
    .load       (timer_load),
    .load_value (timer_load_value),
    .tick       (tick_enable),
    .expired    (timer_expired),
    .count      (timer_count)
  );

  // State register: reset parks the junction in the all-red clearance phase.
  always_ff @(posedge clk or negedge controller_reset) begin
    if (!controller_reset) begin
      state_q <= ALL_RED_B;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: advance on phase expiry; main green also needs demand.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MAIN_GREEN: begin
        if (tick_enable && green_rest_done && demand) begin
          state_d = MAIN_YELLOW;
        end
      end
      MAIN_YELLOW: begin
        if (timer_expired) state_d = ALL_RED_A;
      end
      ALL_RED_A: begin
        if (timer_expired) state_d = SIDE_GREEN;
      end
      SIDE_GREEN: begin
        if (timer_expired) state_d = SIDE_YELLOW;
      end
      SIDE_YELLOW: begin
        if (timer_expired) state_d = ALL_RED_B;
      end
      ALL_RED_B: begin
        if (timer_expired) state_d = MAIN_GREEN;
      end
      default: begin
        state_d = ALL_RED_B;
      end
    endcase
  end

  // Reload the phase timer on every state change, including illegal recovery.
  always_comb begin
    timer_load       = (state_d != state_q);
    timer_load_value = phase_load(state_d);
  end

  // Pedestrian latch: a new press always registers, even on the edge that
  // serves the previous one; the served request is captured into walk_latched.
  always_comb begin
    side_green_entry = (state_d == SIDE_GREEN) && (state_q != SIDE_GREEN);

    ped_pending_d = ped_pending_q;
    if (ped_request) begin
      ped_pending_d = 1'b1;
    end else if (side_green_entry) begin
      ped_pending_d = 1'b0;
    end

    walk_latched_d = walk_latched_q;
    if (side_green_entry) begin
      walk_latched_d = ped_pending_q;
    end else if (state_d != SIDE_GREEN) begin
      walk_latched_d = 1'b0;
    end
  end

  // Pedestrian latch registers; reset discards any request in flight.
  always_ff @(posedge clk or negedge controller_reset) begin
    if (!controller_reset) begin
      ped_pending_q  <= 1'b0;
      walk_latched_q <= 1'b0;
    end else begin
      ped_pending_q  <= ped_pending_d;
      walk_latched_q <= walk_latched_d;
    end
  end

  // Output decode from the next state so the lamps switch on the state edge.
  always_comb begin
    main_light_d = RED;
    side_light_d = RED;
    case (state_d)
      MAIN_GREEN:  main_light_d = GRN;
      MAIN_YELLOW: main_light_d = YEL;
      SIDE_GREEN:  side_light_d = GRN;
      SIDE_YELLOW: side_light_d = YEL;
      default: begin
        main_light_d = RED;
        side_light_d = RED;
      end
    endcase
    walk_d    = (state_d == SIDE_GREEN) && walk_latched_d;
    ped_ack_d = side_green_entry && ped_pending_q;
  end

  // Registered Moore outputs; reset forces both roads red and walk off.
  always_ff @(posedge clk or negedge controller_reset) begin
    if (!controller_reset) begin
      main_light_q <= RED;
      side_light_q <= RED;
      walk_q       <= 1'b0;
      ped_ack_q    <= 1'b0;
    end else begin
      main_light_q <= main_light_d;
      side_light_q <= side_light_d;
      walk_q       <= walk_d;
      ped_ack_q    <= ped_ack_d;
    end
  end

  assign main_light = main_light_q;
  assign side_light = side_light_q;
  assign walk       = walk_q;
  assign ped_ack    = ped_ack_q;

endmodule : traffic_phase_sequencer
`default_nettype wire
